regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Architectural register file and pending-write scoreboard for the five-stage MIPS pipeline. It is the receiving end of the write-back stage's `write_addr_out`/`write_data_out` path: it commits write-back results on the clock edge and serves two combinational operand reads to decode, with a same-cycle write-through bypass. A one-bit-per-register scoreboard tracks outstanding long-latency producers, such as loads. From that scoreboard the block raises a decode hazard whenever a needed source, or the new destination, is still pending.

## Interface
Parameters:
- none. Geometry is fixed at 32 registers x 32 bits; r0 is hardwired to zero.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline stall; blocks scoreboard issue only
- rs_addr  in  5  read port A address
- rt_addr  in  5  read port B address
- rs_used  in  1  decode needs port A operand
- rt_used  in  1  decode needs port B operand
- rs_data  out  32  port A data (combinational)
- rt_data  out  32  port B data (combinational)
- rs_ready  out  1  port A register has no pending producer, or is bypassed this cycle
- rt_ready  out  1  port B equivalent
- issue_valid  in  1  decode issues a long-latency instruction writing issue_dst
- issue_dst  in  5  destination register of the issued instruction
- hazard  out  1  decode must hold; issue is suppressed
- wb_we  in  1  write-back enable (reg_write from write_back)
- wb_addr  in  5  write-back register address
- wb_data  in  32  write-back data
- busy_count  out  6  number of scoreboard bits set (registered)

## Operation
- Storage: regs[1..31], 32 bits each. A read of address 0 returns 0 and ready=1 in every case.
- Write: at posedge, if wb_we && wb_addr!=0, set regs[wb_addr] <= wb_data. Writes are never gated by stall or hazard.
- Read, port A (port B is identical): if rs_addr==0, return 0. Else, if wb_we && wb_addr==rs_addr, return wb_data (bypass). Else return regs[rs_addr].
- Scoreboard busy[31:0], bit 0 constantly 0.
  - Clear: at posedge, if wb_we && wb_addr!=0, busy[wb_addr] <= 0.
  - Set: at posedge, if issue_fire, busy[issue_dst] <= 1.
  - issue_fire = issue_valid && !stall && !hazard && issue_dst!=0.
  - Set and clear on the same address in the same cycle: set wins.
- rs_ready = (rs_addr==0) || !busy[rs_addr] || (wb_we && wb_addr==rs_addr).
- hazard = issue_valid && ((rs_used && !rs_ready) || (rt_used && !rt_ready) || waw).
  - waw = issue_dst!=0 && busy[issue_dst] && !(wb_we && wb_addr==issue_dst).
  - Consequence: at most one outstanding producer per register.
- hazard is independent of stall; stall only masks issue_fire.
- busy_count = popcount of the next-state busy, registered at posedge.
- A write-back to a non-busy register (ALU result) updates data only; the scoreboard is unchanged.

## Timing
- Reset (rstn low, asynchronous): all regs = 0, busy = 0, busy_count = 0.
- Outputs during and immediately after reset:
  - rs_data/rt_data = 0, or wb_data if bypassed.
  - rs_ready/rt_ready = 1.
  - hazard = 0.
- Reset asserted mid-operation discards every pending bit. Write-backs that arrive after reset still write data and do not disturb the scoreboard.
- Read latency: 0 cycles, combinational from address and wb inputs. Write-to-array latency: 1 edge.
- Bypass makes a write-back visible to decode in the same cycle, so there is no one-cycle RAW bubble.
- Issue-to-busy: 1 edge. A dependent instruction in the next cycle sees ready=0 until the cycle its producer's wb_we arrives.
- busy_count lags the busy state by 0 cycles after the edge. Maximum value is 31.

## Test plan
- Reset, then write r5=0x12345678 (wb_we=1). Next cycle read rs_addr=5 -> 0x12345678, rs_ready=1, busy_count=0.
- Bypass case: wb_we=1, wb_addr=7, wb_data=0xDEADBEEF, with rt_addr=7 in the same cycle -> rt_data=0xDEADBEEF. Write to r0 with 0xFFFFFFFF -> reading r0 returns 0.
- Issue load to r9, then hold rs_addr=9, rs_used=1, issue_valid=1 -> hazard=1 and busy_count=1 until the wb to r9 cycle. In that cycle rs_ready=1, hazard=0, data is bypassed, and busy_count is 0 after the edge.
- WAW: with r3 busy, issue_dst=3 -> hazard=1 and no set. In the same cycle as wb to r3 -> hazard=0 and issue fires, so r3 stays busy and busy_count stays 1.
- Stall=1 with issue_valid=1, issue_dst=4 -> busy[4] is not set and busy_count is unchanged. Meanwhile wb to r4=0x55 still commits.
- Issue to r2, r6, r8 (busy_count=3), assert rstn=0 asynchronously mid-cycle -> busy_count=0, all ready=1, all reads=0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode / write-back bundle for the register file and pending-write scoreboard.
// The master side is the pipeline (decode + write-back); the slave is the register file.
interface regfile_scoreboard_if;
    logic        stall;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_ready;
    logic        rt_ready;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        hazard;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  busy_count;

    modport master (
        output stall, rs_addr, rt_addr, rs_used, rt_used,
        output issue_valid, issue_dst, wb_we, wb_addr, wb_data,
        input  rs_data, rt_data, rs_ready, rt_ready, hazard, busy_count
    );

    modport slave (
        input  stall, rs_addr, rt_addr, rs_used, rt_used,
        input  issue_valid, issue_dst, wb_we, wb_addr, wb_data,
        output rs_data, rt_data, rs_ready, rt_ready, hazard, busy_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file (32 x 32, r0 hardwired to zero) with a
// write-through bypass on both read ports and a one-bit-per-register
// scoreboard of outstanding long-latency producers that drives the
// decode hazard.
module regfile_scoreboard (
    input  logic                 clk,
    input  logic                 rstn,
    regfile_scoreboard_if.slave  bus
);

    // Number of set bits in a 32-bit vector.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    logic [31:0] regs_r [0:31];
    logic [31:0] busy_r;
    logic [31:0] busy_s;
    logic [5:0]  busy_count_r;

    logic        wb_commit_s;
    logic        rs_bypass_s;
    logic        rt_bypass_s;
    logic        dst_bypass_s;
    logic        rs_ready_s;
    logic        rt_ready_s;
    logic        waw_s;
    logic        hazard_s;
    logic        issue_fire_s;

    // Bypass matches and the write-back commit qualifier (r0 is never written).
    always_comb begin
        wb_commit_s  = bus.wb_we && (bus.wb_addr != 5'd0);
        rs_bypass_s  = bus.wb_we && (bus.wb_addr == bus.rs_addr);
        rt_bypass_s  = bus.wb_we && (bus.wb_addr == bus.rt_addr);
        dst_bypass_s = bus.wb_we && (bus.wb_addr == bus.issue_dst);
    end

    // Operand reads: r0 reads zero, a same-cycle write-back wins over the array.
    always_comb begin
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        if (bus.rs_addr == 5'd0) begin
            bus.rs_data = 32'd0;
        end else if (rs_bypass_s) begin
            bus.rs_data = bus.wb_data;
        end else begin
            bus.rs_data = regs_r[bus.rs_addr];
        end
        if (bus.rt_addr == 5'd0) begin
            bus.rt_data = 32'd0;
        end else if (rt_bypass_s) begin
            bus.rt_data = bus.wb_data;
        end else begin
            bus.rt_data = regs_r[bus.rt_addr];
        end
    end

    // Operand readiness, WAW check and the resulting decode hazard / issue fire.
    always_comb begin
        rs_ready_s   = (bus.rs_addr == 5'd0) || !busy_r[bus.rs_addr] || rs_bypass_s;
        rt_ready_s   = (bus.rt_addr == 5'd0) || !busy_r[bus.rt_addr] || rt_bypass_s;
        waw_s        = (bus.issue_dst != 5'd0) && busy_r[bus.issue_dst] && !dst_bypass_s;
        hazard_s     = bus.issue_valid &&
                       ((bus.rs_used && !rs_ready_s) ||
                        (bus.rt_used && !rt_ready_s) ||
                        waw_s);
        issue_fire_s = bus.issue_valid && !bus.stall && !hazard_s &&
                       (bus.issue_dst != 5'd0);
        bus.rs_ready = rs_ready_s;
        bus.rt_ready = rt_ready_s;
        bus.hazard   = hazard_s;
    end

    // Next scoreboard state: write-back clears, issue sets, set applied last so it wins.
    always_comb begin
        busy_s = busy_r;
        if (wb_commit_s) begin
            busy_s[bus.wb_addr] = 1'b0;
        end else begin
            busy_s = busy_s;
        end
        if (issue_fire_s) begin
            busy_s[bus.issue_dst] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
        busy_s[0] = 1'b0;
    end

    // Register array: write-back commits regardless of stall or hazard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_commit_s) begin
            regs_r[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard bits and their population count, both updated on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r       <= 32'd0;
            busy_count_r <= 6'd0;
        end else begin
            busy_r       <= busy_s;
            busy_count_r <= popcount32(busy_s);
        end
    end

    assign bus.busy_count = busy_count_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run compared against a behavioural model that keeps the
// outstanding producers as a set of register numbers.
module tb_regfile_scoreboard;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    regfile_scoreboard_if bus();

    regfile_scoreboard dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    int          pending [int];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        pending.delete();
    endfunction

    function automatic bit m_busy(int r);
        return pending.exists(r);
    endfunction

    function automatic bit wb_hits(int r);
        return bus.wb_we && (int'(bus.wb_addr) == r);
    endfunction

    function automatic logic [31:0] m_read(int r);
        if (r == 0) return 32'd0;
        if (wb_hits(r)) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_ready(int r);
        return (r == 0) || !m_busy(r) || wb_hits(r);
    endfunction

    function automatic bit m_hazard();
        bit waw;
        int d;
        d   = int'(bus.issue_dst);
        waw = (d != 0) && m_busy(d) && !wb_hits(d);
        return bus.issue_valid &&
               ((bus.rs_used && !m_ready(int'(bus.rs_addr))) ||
                (bus.rt_used && !m_ready(int'(bus.rt_addr))) || waw);
    endfunction

    // Advance one clock edge, applying the pre-edge inputs to the model.
    task automatic tick();
        bit          fire;
        bit          we;
        int          wa;
        int          dst;
        logic [31:0] wd;
        fire = bus.issue_valid && !bus.stall && !m_hazard() && (bus.issue_dst != 5'd0);
        we   = bus.wb_we;
        wa   = int'(bus.wb_addr);
        wd   = bus.wb_data;
        dst  = int'(bus.issue_dst);
        @(posedge clk);
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            if (pending.exists(wa)) pending.delete(wa);
        end
        if (fire) pending[dst] = 1;
        #1;
    endtask

    task automatic set_idle();
        bus.stall       = 1'b0;
        bus.rs_addr     = 5'd0;
        bus.rt_addr     = 5'd0;
        bus.rs_used     = 1'b0;
        bus.rt_used     = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_dst   = 5'd0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        set_idle();
        model_reset();
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd17;
        #12;
        n_tests++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.busy_count); end
        n_tests++; if (bus.rs_ready !== 1'b1 || bus.rt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b%b want 11", bus.rs_ready, bus.rt_ready); end
        n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", bus.hazard); end
        n_tests++; if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h/%h want 0", bus.rs_data, bus.rt_data); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        set_idle();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234_5678;
        tick();
        set_idle();
        bus.rs_addr = 5'd5;
        #1;
        n_tests++; if (bus.rs_data !== 32'h1234_5678) begin n_fail++; $display("FAIL write_read_data got %h want 12345678", bus.rs_data); end
        n_tests++; if (bus.rs_ready !== 1'b1) begin n_fail++; $display("FAIL write_read_ready got %b want 1", bus.rs_ready); end
        n_tests++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL write_read_count got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_bypass();
        set_idle();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hDEAD_BEEF;
        bus.rt_addr = 5'd7;
        #1;
        n_tests++; if (bus.rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rt got %h want deadbeef", bus.rt_data); end
        tick();
        set_idle();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.rs_addr = 5'd0;
        #1;
        n_tests++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL r0_bypass got %h want 0", bus.rs_data); end
        tick();
        set_idle();
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd7;
        #1;
        n_tests++; if (bus.rs_data !== 32'd0 || bus.rs_ready !== 1'b1) begin n_fail++; $display("FAIL r0_read got %h/%b want 0/1", bus.rs_data, bus.rs_ready); end
        n_tests++; if (bus.rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL r7_read got %h want deadbeef", bus.rt_data); end
    endtask

    task automatic test_load_hazard();
        set_idle();
        bus.issue_valid = 1'b1; bus.issue_dst = 5'd9;
        tick();
        n_tests++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL load_count got %0d want 1", bus.busy_count); end
        set_idle();
        bus.rs_addr = 5'd9; bus.rs_used = 1'b1; bus.issue_valid = 1'b1; bus.issue_dst = 5'd0;
        #1;
        n_tests++; if (bus.hazard !== 1'b1 || bus.rs_ready !== 1'b0) begin n_fail++; $display("FAIL raw_hazard got hz=%b rdy=%b want 1/0", bus.hazard, bus.rs_ready); end
        tick();
        n_tests++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL raw_hold_count got %0d want 1", bus.busy_count); end
        bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h0BAD_F00D;
        #1;
        n_tests++; if (bus.rs_ready !== 1'b1 || bus.hazard !== 1'b0) begin n_fail++; $display("FAIL wb_release got rdy=%b hz=%b want 1/0", bus.rs_ready, bus.hazard); end
        n_tests++; if (bus.rs_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wb_release_data got %h want 0badf00d", bus.rs_data); end
        tick();
        n_tests++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL wb_release_count got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_waw();
        set_idle();
        bus.issue_valid = 1'b1; bus.issue_dst = 5'd3;
        tick();
        #1;
        n_tests++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL waw_hazard got %b want 1", bus.hazard); end
        tick();
        n_tests++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL waw_count got %0d want 1", bus.busy_count); end
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h3333_3333;
        #1;
        n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL waw_release got %b want 0", bus.hazard); end
        tick();
        n_tests++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL waw_refire_count got %0d want 1", bus.busy_count); end
        set_idle();
        bus.rs_addr = 5'd3;
        #1;
        n_tests++; if (bus.rs_ready !== 1'b0) begin n_fail++; $display("FAIL waw_still_busy got %b want 0", bus.rs_ready); end
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h4444_4444;
        tick();
        set_idle();
    endtask

    task automatic test_stall();
        set_idle();
        bus.stall = 1'b1; bus.issue_valid = 1'b1; bus.issue_dst = 5'd4;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_0055;
        #1;
        n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL stall_hazard got %b want 0", bus.hazard); end
        tick();
        n_tests++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL stall_count got %0d want 0", bus.busy_count); end
        set_idle();
        bus.rs_addr = 5'd4;
        #1;
        n_tests++; if (bus.rs_data !== 32'h0000_0055 || bus.rs_ready !== 1'b1) begin n_fail++; $display("FAIL stall_wb got %h/%b want 00000055/1", bus.rs_data, bus.rs_ready); end
    endtask

    task automatic test_async_reset();
        set_idle();
        bus.issue_valid = 1'b1;
        bus.issue_dst = 5'd2; tick();
        bus.issue_dst = 5'd6; tick();
        bus.issue_dst = 5'd8; tick();
        set_idle();
        #1;
        n_tests++; if (bus.busy_count !== 6'd3) begin n_fail++; $display("FAIL three_busy got %0d want 3", bus.busy_count); end
        #1;
        rstn = 1'b0;
        model_reset();
        bus.rs_addr = 5'd2; bus.rt_addr = 5'd5;
        #1;
        n_tests++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL async_count got %0d want 0", bus.busy_count); end
        n_tests++; if (bus.rs_ready !== 1'b1 || bus.rt_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got %b%b want 11", bus.rs_ready, bus.rt_ready); end
        n_tests++; if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin n_fail++; $display("FAIL async_data got %h/%h want 0", bus.rs_data, bus.rt_data); end
        rstn = 1'b1;
        @(posedge clk); #1;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h6666_0006;
        tick();
        set_idle();
        bus.rs_addr = 5'd6;
        #1;
        n_tests++; if (bus.rs_data !== 32'h6666_0006 || bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL post_reset_wb got %h/%0d want 66660006/0", bus.rs_data, bus.busy_count); end
    endtask

    task automatic test_random();
        set_idle();
        for (int c = 0; c < 400; c++) begin
            bus.stall       = ($urandom_range(0, 4) == 0);
            bus.rs_addr     = 5'($urandom_range(0, 7));
            bus.rt_addr     = 5'($urandom_range(0, 7));
            bus.rs_used     = 1'($urandom_range(0, 1));
            bus.rt_used     = 1'($urandom_range(0, 1));
            bus.issue_valid = ($urandom_range(0, 1) == 1);
            bus.issue_dst   = 5'($urandom_range(0, 7));
            bus.wb_we       = ($urandom_range(0, 4) < 2);
            bus.wb_addr     = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            #1;
            n_tests++; if (bus.rs_data !== m_read(int'(bus.rs_addr))) begin n_fail++; $display("FAIL rnd_rs_data c=%0d got %h want %h", c, bus.rs_data, m_read(int'(bus.rs_addr))); end
            n_tests++; if (bus.rt_data !== m_read(int'(bus.rt_addr))) begin n_fail++; $display("FAIL rnd_rt_data c=%0d got %h want %h", c, bus.rt_data, m_read(int'(bus.rt_addr))); end
            n_tests++; if (bus.rs_ready !== m_ready(int'(bus.rs_addr)) || bus.rt_ready !== m_ready(int'(bus.rt_addr))) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b%b want %b%b", c, bus.rs_ready, bus.rt_ready, m_ready(int'(bus.rs_addr)), m_ready(int'(bus.rt_addr))); end
            n_tests++; if (bus.hazard !== m_hazard()) begin n_fail++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, bus.hazard, m_hazard()); end
            tick();
            n_tests++; if (int'(bus.busy_count) != pending.num()) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.busy_count, pending.num()); end
        end
        set_idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_load_hazard();
        test_waw();
        test_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
